// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath stages: the accumulator state
// encoding, default widths and the multiplier latency that operand sources
// align their product beats to.
package mac_pkg;

  localparam int DEF_WIDTH_P   = 36;
  localparam int DEF_ACC_WIDTH = 48;
  localparam int DEF_CNT_WIDTH = 16;
  localparam int MULT_LATENCY  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;

endpackage

// File: rtl/product_accumulator_if.sv
// Product stream in and vector result out for the product accumulator.
// The master modport is the side that drives the products and consumes
// the results; the slave modport is the accumulator.
interface product_accumulator_if
  import mac_pkg::*;
#(
  parameter int WIDTH_P   = DEF_WIDTH_P,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) ();

  logic [WIDTH_P-1:0]   p_data;
  logic                 p_valid;
  logic                 p_last;
  logic                 p_ready;

  logic [ACC_WIDTH-1:0] acc_data;
  logic [CNT_WIDTH-1:0] acc_count;
  logic                 acc_ovf;
  logic                 acc_valid;
  logic                 acc_ready;

  modport master (
    output p_data, p_valid, p_last, acc_ready,
    input  p_ready, acc_data, acc_count, acc_ovf, acc_valid
  );

  modport slave (
    input  p_data, p_valid, p_last, acc_ready,
    output p_ready, acc_data, acc_count, acc_ovf, acc_valid
  );

endinterface

// File: rtl/product_accumulator_result_out_reg.sv
// One-entry valid/ready output register. A load always wins over a drain,
// so a result leaving and a new one arriving in the same cycle keeps
// out_valid high with the new contents. Kept generic so other MAC stages
// can reuse it.
module result_out_reg #(
  parameter int DATA_W = 48,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CNT_W-1:0]  load_count,
  input  logic              load_ovf,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf,
  input  logic              out_ready
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;

  // Next-state: drain on transfer, capture on load (load has priority).
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      count_d = load_count;
      ovf_d   = load_ovf;
    end
  end

  // Output register with synchronous reset that discards any pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_count = count_q;
  assign out_ovf   = ovf_q;

endmodule

// File: rtl/product_accumulator.sv
// Accumulate half of the MAC datapath: sums a stream of unsigned products
// into a saturating wide sum and hands one result per vector (closed by
// p_last) to a one-entry output register.
//
//   state | meaning
//   IDLE  | no vector in progress; sum, count and ovf are clear
//   ACCUM | vector in progress; sum/count/ovf hold the partial result
//
// Completion returns to IDLE in the same cycle the result is stored, so a
// new vector can start on the very next beat.
module product_accumulator
  import mac_pkg::*;
#(
  parameter int WIDTH_P   = DEF_WIDTH_P,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input logic                   clk,
  input logic                   rst,
  product_accumulator_if.slave  bus
);

  acc_state_e           state_q, state_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  logic [ACC_WIDTH-1:0] sum_base, sum_next;
  logic [CNT_WIDTH-1:0] cnt_base, cnt_next;
  logic                 ovf_base, ovf_next;
  logic [ACC_WIDTH:0]   add_full;
  logic                 accept;
  logic                 complete;
  logic                 out_valid;

  // The stage only stalls when a finished result has nowhere to go. Beats
  // offered while stalled are a source protocol error and are dropped.
  assign bus.p_ready = rst | ~out_valid | bus.acc_ready;
  assign accept      = bus.p_valid & bus.p_ready;

  // Saturating add of the zero-extended product and saturating term count.
  always_comb begin
    sum_base = (state_q == IDLE) ? '0 : sum_q;
    cnt_base = (state_q == IDLE) ? '0 : cnt_q;
    ovf_base = (state_q == IDLE) ? 1'b0 : ovf_q;
    add_full = {1'b0, sum_base} + {1'b0, ACC_WIDTH'(bus.p_data)};
    sum_next = add_full[ACC_WIDTH] ? '1 : add_full[ACC_WIDTH-1:0];
    ovf_next = ovf_base | add_full[ACC_WIDTH];
    cnt_next = (&cnt_base) ? cnt_base : cnt_base + 1'b1;
  end

  // FSM next-state: accumulate on non-last beats, hand off and clear on last.
  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    complete = 1'b0;
    if (accept) begin
      if (bus.p_last) begin
        complete = 1'b1;
        state_d  = IDLE;
        sum_d    = '0;
        cnt_d    = '0;
        ovf_d    = 1'b0;
      end else begin
        state_d  = ACCUM;
        sum_d    = sum_next;
        cnt_d    = cnt_next;
        ovf_d    = ovf_next;
      end
    end
  end

  // FSM and partial-sum registers; reset discards any vector in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sum_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  result_out_reg #(
    .DATA_W (ACC_WIDTH),
    .CNT_W  (CNT_WIDTH)
  ) u_out (
    .clk        (clk),
    .rst        (rst),
    .load       (complete),
    .load_data  (sum_next),
    .load_count (cnt_next),
    .load_ovf   (ovf_next),
    .out_valid  (out_valid),
    .out_data   (bus.acc_data),
    .out_count  (bus.acc_count),
    .out_ovf    (bus.acc_ovf),
    .out_ready  (bus.acc_ready)
  );

  assign bus.acc_valid = out_valid;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: the stimulus pushes expected
// results as vectors are sent, a monitor pops and compares on each result
// transfer. ACC_WIDTH is WIDTH_P+1 so saturation is reachable in 4 beats.
module tb_product_accumulator;
  import mac_pkg::*;

  localparam int WP = 36;
  localparam int AW = WP + 1;
  localparam int CW = 16;

  typedef struct packed {
    logic [AW-1:0] data;
    logic [CW-1:0] cnt;
    logic          ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  res_t mon_e;

  always #5 clk = ~clk;

  product_accumulator_if #(.WIDTH_P(WP), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  product_accumulator #(.WIDTH_P(WP), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // The source must never offer a beat the stage cannot take.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(bus.p_valid && !bus.p_ready))
        else $error("protocol: p_valid while p_ready low");
    end
  end

  // Monitor: every result transfer is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.acc_valid && bus.acc_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result got data=%0h cnt=%0d ovf=%0b",
                 bus.acc_data, bus.acc_count, bus.acc_ovf);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.acc_data !== mon_e.data || bus.acc_count !== mon_e.cnt ||
            bus.acc_ovf !== mon_e.ovf) begin
          errors++;
          $display("FAIL result got data=%0h cnt=%0d ovf=%0b want data=%0h cnt=%0d ovf=%0b",
                   bus.acc_data, bus.acc_count, bus.acc_ovf,
                   mon_e.data, mon_e.cnt, mon_e.ovf);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Present one beat (or idle) for one cycle; returns 1 time unit after the edge.
  task automatic drive(input logic v, input logic [WP-1:0] d, input logic l);
    bus.p_valid = v;
    bus.p_data  = d;
    bus.p_last  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input logic [AW-1:0] d, input logic [CW-1:0] c, input logic o);
    res_t r;
    r.data = d;
    r.cnt  = c;
    r.ovf  = o;
    exp_q.push_back(r);
  endtask

  localparam logic [WP-1:0] ONES_P = '1;
  localparam logic [AW-1:0] ONES_A = '1;

  initial begin
    bus.p_valid   = 1'b0;
    bus.p_data    = '0;
    bus.p_last    = 1'b0;
    bus.acc_ready = 1'b1;
    rst = 1'b1;
    drive(0, 0, 0);
    drive(0, 0, 0);
    chk("rst_valid", 64'(bus.acc_valid), 64'd0);
    chk("rst_data",  64'(bus.acc_data),  64'd0);
    chk("rst_count", 64'(bus.acc_count), 64'd0);
    chk("rst_ovf",   64'(bus.acc_ovf),   64'd0);
    chk("rst_p_ready", 64'(bus.p_ready), 64'd1);
    rst = 1'b0;
    drive(0, 0, 0);

    // Vector 3,5,7: result one cycle after the last beat, for exactly one cycle.
    drive(1, 3, 0);
    drive(1, 5, 0);
    chk("v1_no_early_valid", 64'(bus.acc_valid), 64'd0);
    expect_res(15, 3, 0);
    drive(1, 7, 1);
    chk("v1_valid", 64'(bus.acc_valid), 64'd1);
    drive(0, 0, 0);
    chk("v1_valid_one_cycle", 64'(bus.acc_valid), 64'd0);

    // Single-term vector.
    expect_res(42, 1, 0);
    drive(1, 42, 1);
    drive(0, 0, 0);

    // Back-to-back {1,2} then {10}: no bubble, p_ready stays high.
    expect_res(3, 2, 0);
    expect_res(10, 1, 0);
    drive(1, 1, 0);
    chk("b2b_p_ready0", 64'(bus.p_ready), 64'd1);
    drive(1, 2, 1);
    chk("b2b_p_ready1", 64'(bus.p_ready), 64'd1);
    drive(1, 10, 1);
    chk("b2b_valid2", 64'(bus.acc_valid), 64'd1);
    chk("b2b_data2", 64'(bus.acc_data), 64'd10);
    drive(0, 0, 0);
    chk("b2b_drained", 64'(bus.acc_valid), 64'd0);

    // Backpressure: result 3 held while acc_ready low, released on acc_ready.
    drive(1, 1, 0);
    bus.acc_ready = 1'b0;
    expect_res(3, 2, 0);
    drive(1, 2, 1);
    chk("bp_p_ready_low", 64'(bus.p_ready), 64'd0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    chk("bp_valid_hold", 64'(bus.acc_valid), 64'd1);
    chk("bp_data_hold", 64'(bus.acc_data), 64'd3);
    chk("bp_p_ready_hold", 64'(bus.p_ready), 64'd0);
    bus.acc_ready = 1'b1;
    #1;
    chk("bp_p_ready_release", 64'(bus.p_ready), 64'd1);
    drive(0, 0, 0);
    chk("bp_drained", 64'(bus.acc_valid), 64'd0);

    // Saturation over four all-ones beats, then ovf cleared for the next vector.
    expect_res(ONES_A, 4, 1);
    drive(1, ONES_P, 0);
    drive(1, ONES_P, 0);
    drive(1, ONES_P, 0);
    drive(1, ONES_P, 1);
    chk("ovf_flag", 64'(bus.acc_ovf), 64'd1);
    drive(0, 0, 0);
    expect_res(1, 1, 0);
    drive(1, 1, 1);
    chk("ovf_cleared", 64'(bus.acc_ovf), 64'd0);
    drive(0, 0, 0);

    // Reset mid-vector: partial sum discarded, no spurious result.
    drive(1, 100, 0);
    drive(1, 200, 0);
    rst = 1'b1;
    drive(0, 0, 0);
    rst = 1'b0;
    drive(0, 0, 0);
    chk("rst_mid_no_valid", 64'(bus.acc_valid), 64'd0);
    expect_res(4, 1, 0);
    drive(1, 4, 1);
    drive(0, 0, 0);

    // Bounded drain of anything still outstanding.
    for (int i = 0; i < 20 + MULT_LATENCY && exp_q.size() != 0; i++) begin
      @(posedge clk);
    end
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
